// File: rtl/lfsr4_pkg.sv
// Shared definitions for the lfsr4 generator/checker pair.
//   TAP        : feedback tap mask per polynomial select (mod)
//   state_e    : checker synchronisation state
//   next_word(): one LFSR step, fb = ^(w & TAP[mod]), shift left, fb into bit 0
package lfsr4_pkg;

  localparam logic [3:0] TAP [8] = '{
    4'b1100, 4'b1001, 4'b1111, 4'b0110, 4'b1010, 4'b0011, 4'b1110, 4'b0101
  };

  typedef enum logic [1:0] {
    StSearch = 2'd0,
    StVerify = 2'd1,
    StLocked = 2'd2
  } state_e;

  function automatic logic [3:0] next_word(input logic [3:0] w, input logic [2:0] mod);
    return {w[2:0], ^(w & TAP[mod])};
  endfunction

endpackage

// File: rtl/lfsr4_checker_if.sv
// Bus between a pattern source and the lfsr4 checker.
//   mod, din, din_valid, clear_cnt : source -> checker
//   lock, err_pulse, err_count     : checker -> source
interface lfsr4_checker_if #(
  parameter int unsigned CNT_W = 8
);
  logic [2:0]       mod;
  logic [3:0]       din;
  logic             din_valid;
  logic             clear_cnt;
  logic             lock;
  logic             err_pulse;
  logic [CNT_W-1:0] err_count;

  modport master (
    output mod, din, din_valid, clear_cnt,
    input  lock, err_pulse, err_count
  );

  modport slave (
    input  mod, din, din_valid, clear_cnt,
    output lock, err_pulse, err_count
  );
endinterface

// File: rtl/lfsr4_next.sv
// Combinational next-word function of the lfsr4 sequence.
//   w_i    : current word
//   mod_i  : polynomial select
//   next_o : word that follows w_i
module lfsr4_next
  import lfsr4_pkg::*;
(
  input  logic [3:0] w_i,
  input  logic [2:0] mod_i,
  output logic [3:0] next_o
);

  assign next_o = next_word(w_i, mod_i);

endmodule

// File: rtl/lfsr4_checker.sv
// Receive-side PRBS checker for the lfsr4 word stream. Seeds from the incoming
// stream, verifies LOCK_MATCHES consecutive predictions before declaring lock,
// then flywheels its own prediction and counts mismatches (saturating).
//   clk   : clock, rising edge
//   reset : asynchronous active-high reset
//   bus   : slave side of lfsr4_checker_if (mod/din/din_valid/clear_cnt in,
//           lock/err_pulse/err_count out, all outputs registered)
module lfsr4_checker
  import lfsr4_pkg::*;
#(
  parameter int unsigned LOCK_MATCHES = 4,
  parameter int unsigned LOSS_MISSES  = 3,
  parameter int unsigned CNT_W        = 8
) (
  input  logic            clk,
  input  logic            reset,
  lfsr4_checker_if.slave  bus
);

  localparam logic [3:0] LockM = 4'(LOCK_MATCHES);
  localparam logic [3:0] LossM = 4'(LOSS_MISSES);

  state_e           state_q, state_d;
  logic [3:0]       pred_q, pred_d;
  logic [3:0]       match_q, match_d;
  logic [3:0]       miss_q, miss_d;
  logic [2:0]       mod_q;
  logic             lock_q, lock_d;
  logic             err_pulse_q, err_pulse_d;
  logic [CNT_W-1:0] err_count_q, err_count_d;

  logic [3:0] seed_next;
  logic [3:0] fly_next;
  logic       mod_change;
  logic       counted_miss;

  // Seed path predicts from the received word, flywheel path from our own prediction.
  lfsr4_next u_seed (
    .w_i    (bus.din),
    .mod_i  (bus.mod),
    .next_o (seed_next)
  );

  lfsr4_next u_fly (
    .w_i    (pred_q),
    .mod_i  (bus.mod),
    .next_o (fly_next)
  );

  assign mod_change = (bus.mod != mod_q);

  always_comb begin
    state_d      = state_q;
    pred_d       = pred_q;
    match_d      = match_q;
    miss_d       = miss_q;
    err_pulse_d  = 1'b0;
    err_count_d  = err_count_q;
    counted_miss = 1'b0;

    if (mod_change) begin
      // Polynomial switched: the sample this cycle belongs to neither sequence.
      state_d = StSearch;
      match_d = '0;
      miss_d  = '0;
    end else if (bus.din_valid) begin
      unique case (state_q)
        StSearch: begin
          if (bus.din != 4'd0) begin
            pred_d  = seed_next;
            match_d = '0;
            state_d = StVerify;
          end
        end
        StVerify: begin
          if (bus.din == pred_q) begin
            pred_d  = seed_next;
            match_d = match_q + 4'd1;
            if (match_d == LockM) begin
              state_d = StLocked;
              miss_d  = '0;
            end
          end else if (bus.din != 4'd0) begin
            pred_d  = seed_next;
            match_d = '0;
          end else begin
            state_d = StSearch;
            match_d = '0;
          end
        end
        StLocked: begin
          pred_d = fly_next;
          if (bus.din == pred_q) begin
            miss_d = '0;
          end else begin
            counted_miss = 1'b1;
            err_pulse_d  = 1'b1;
            miss_d       = miss_q + 4'd1;
            if (miss_d == LossM) begin
              state_d = StSearch;
              miss_d  = '0;
              match_d = '0;
            end
          end
        end
        default: state_d = StSearch;
      endcase
    end

    if (counted_miss && (err_count_q != {CNT_W{1'b1}})) begin
      err_count_d = err_count_q + 1'b1;
    end
    // Clear takes priority over a coincident count; the pulse still fires.
    if (bus.clear_cnt) begin
      err_count_d = '0;
    end

    lock_d = (state_d == StLocked);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StSearch;
      pred_q      <= '0;
      match_q     <= '0;
      miss_q      <= '0;
      mod_q       <= '0;
      lock_q      <= 1'b0;
      err_pulse_q <= 1'b0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      pred_q      <= pred_d;
      match_q     <= match_d;
      miss_q      <= miss_d;
      mod_q       <= bus.mod;
      lock_q      <= lock_d;
      err_pulse_q <= err_pulse_d;
      err_count_q <= err_count_d;
    end
  end

  assign bus.lock      = lock_q;
  assign bus.err_pulse = err_pulse_q;
  assign bus.err_count = err_count_q;

endmodule

// File: tb/tb_lfsr4_checker.sv
module tb_lfsr4_checker;

  logic clk;
  logic reset;
  int   tests;
  int   fails;

  lfsr4_checker_if #(.CNT_W(8)) bus_a ();
  lfsr4_checker_if #(.CNT_W(8)) bus_b ();

  // Second build (LOSS_MISSES=15) sees the same stimulus.
  assign bus_b.mod       = bus_a.mod;
  assign bus_b.din       = bus_a.din;
  assign bus_b.din_valid = bus_a.din_valid;
  assign bus_b.clear_cnt = bus_a.clear_cnt;

  lfsr4_checker #(.LOCK_MATCHES(4), .LOSS_MISSES(3), .CNT_W(8)) u_dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_a)
  );

  lfsr4_checker #(.LOCK_MATCHES(4), .LOSS_MISSES(15), .CNT_W(8)) u_dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // mod=0 taps 1100: fb = w[3]^w[2]
  function automatic logic [3:0] nx0(input logic [3:0] w);
    return {w[2:0], w[3] ^ w[2]};
  endfunction

  task automatic check(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cycle(input logic [3:0] d, input logic v);
    bus_a.din       = d;
    bus_a.din_valid = v;
    @(posedge clk);
    #1;
  endtask

  task automatic check_a(input string tag, input int lk, input int pl, input int cnt);
    check({tag, ".lock"}, int'(bus_a.lock), lk);
    check({tag, ".err_pulse"}, int'(bus_a.err_pulse), pl);
    check({tag, ".err_count"}, int'(bus_a.err_count), cnt);
  endtask

  logic [3:0] seq [5];
  logic [3:0] p;

  initial begin
    tests = 0;
    fails = 0;
    seq[0] = 4'd1; seq[1] = 4'd2; seq[2] = 4'd4; seq[3] = 4'd9; seq[4] = 4'd3;
    reset           = 1'b1;
    bus_a.mod       = 3'd0;
    bus_a.din       = 4'd0;
    bus_a.din_valid = 1'b0;
    bus_a.clear_cnt = 1'b0;

    // 1. reset held with random traffic
    for (int i = 0; i < 4; i++) cycle(4'($urandom), 1'($urandom));
    check_a("reset_held", 0, 0, 0);
    reset = 1'b0;
    for (int i = 0; i < 2; i++) cycle(4'($urandom), 1'b0);
    check_a("after_release", 0, 0, 0);

    // 5. all-zero stream never leaves SEARCH
    for (int i = 0; i < 20; i++) begin
      cycle(4'd0, 1'b1);
      check("zero_stream.lock", int'(bus_a.lock), 0);
    end
    check("zero_stream.err_count", int'(bus_a.err_count), 0);

    // 2. lock after 5th sample
    for (int i = 0; i < 5; i++) begin
      cycle(seq[i], 1'b1);
      check_a($sformatf("acquire%0d", i), (i == 4) ? 1 : 0, 0, 0);
    end

    // 3. single wrong word (7 instead of 6), then correct 13, 10
    cycle(4'd7, 1'b1);
    check_a("single_err", 1, 1, 1);
    cycle(4'd13, 1'b1);
    check_a("after_err13", 1, 0, 1);
    cycle(4'd10, 1'b1);
    check_a("after_err10", 1, 0, 1);
    cycle(4'd3, 1'b0);
    check_a("invalid_hold", 1, 0, 1);

    // 4. three consecutive misses (pred is 5) lose lock on the third
    cycle(4'd0, 1'b1);
    check_a("miss1", 1, 1, 2);
    cycle(4'd0, 1'b1);
    check_a("miss2", 1, 1, 3);
    cycle(4'd0, 1'b1);
    check_a("miss3", 0, 1, 4);
    for (int i = 0; i < 5; i++) begin
      cycle(seq[i], 1'b1);
      check_a($sformatf("relock%0d", i), (i == 4) ? 1 : 0, 0, 4);
    end

    // 6a. mod change drops lock, ignores the sample, keeps the count
    bus_a.mod = 3'd1;
    cycle(4'd6, 1'b1);
    check_a("mod_change", 0, 0, 4);
    bus_a.mod = 3'd0;
    cycle(4'd0, 1'b0);
    check_a("mod_back", 0, 0, 4);
    for (int i = 0; i < 5; i++) cycle(seq[i], 1'b1);
    check_a("relock_mod0", 1, 0, 4);

    // 6b. clear coincident with a counted mismatch
    bus_a.clear_cnt = 1'b1;
    cycle(4'd0, 1'b1);
    bus_a.clear_cnt = 1'b0;
    check_a("clear_vs_miss", 1, 1, 0);

    // 6c. saturation: alternate wrong/correct so neither build loses lock
    reset = 1'b1;
    cycle(4'd0, 1'b0);
    reset = 1'b0;
    check("sat_reset.a", int'(bus_a.err_count), 0);
    check("sat_reset.b", int'(bus_b.err_count), 0);
    for (int i = 0; i < 5; i++) cycle(seq[i], 1'b1);
    check("sat_lock.b", int'(bus_b.lock), 1);
    p = nx0(4'd3);
    for (int i = 0; i < 300; i++) begin
      cycle(4'd0, 1'b1);
      if (i == 99) check("sat_mid.b", int'(bus_b.err_count), 100);
      p = nx0(p);
      cycle(p, 1'b1);
      p = nx0(p);
    end
    check("sat_end.b", int'(bus_b.err_count), 255);
    check("sat_end.b_lock", int'(bus_b.lock), 1);
    check_a("sat_end.a", 1, 0, 255);
    cycle(4'd0, 1'b1);
    check("sat_hold.b", int'(bus_b.err_count), 255);
    check("sat_hold.b_pulse", int'(bus_b.err_pulse), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
